// File: rtl/ofm_drain_if.sv
// ofm_drain_if -- bundle of the drain engine's array-side and stream-side signals.
//
// Ports (as seen from the master, i.e. the ofm_drain block):
//   start     in   one-cycle request to drain a finished tile
//   ofm       in   per-column result outputs of the array (WIDTH x OWIDTH)
//   en_o      out  per-column shift enable into the array
//   clr_o     out  per-column accumulator clear into the array
//   out_vld   out  out_data holds a valid row
//   out_rdy   in   downstream accepts the row
//   out_data  out  one deskewed result row, element w from column w
//   out_row   out  index of the row on out_data
//   out_last  out  row on out_data is the final row of the tile
//   busy      out  engine is not idle
interface ofm_drain_if #(
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int OWIDTH = 24
);
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic                           start;
    logic [WIDTH-1:0][OWIDTH-1:0]   ofm;
    logic [WIDTH-1:0]               en_o;
    logic [WIDTH-1:0]               clr_o;
    logic                           out_vld;
    logic                           out_rdy;
    logic [WIDTH-1:0][OWIDTH-1:0]   out_data;
    logic [RW-1:0]                  out_row;
    logic                           out_last;
    logic                           busy;

    modport master (
        input  start, ofm, out_rdy,
        output en_o, clr_o, out_vld, out_data, out_row, out_last, busy
    );

    modport slave (
        output start, ofm, out_rdy,
        input  en_o, clr_o, out_vld, out_data, out_row, out_last, busy
    );
endinterface

// File: rtl/ofm_drain.sv
// ofm_drain -- drains a finished HEIGHT x WIDTH result tile out of a systolic
// array. Column w shifts its results out one cycle later than column w-1, so
// the engine issues skewed per-column enables, captures each column into a
// row-addressed buffer, clears each column's accumulators right after its
// last result, and finally streams the deskewed rows over a valid/ready port.
//
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  ofm_drain_if.master (start, ofm, en_o, clr_o, out_vld, out_rdy,
//        out_data, out_row, out_last, busy)
module ofm_drain #(
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int OWIDTH = 24
) (
    input  logic        clk,
    input  logic        rst,
    ofm_drain_if.master bus
);
    localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TW     = $clog2(HEIGHT + WIDTH);
    localparam int T_LAST = HEIGHT + WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_t;     // drain cycle counter, 0 .. HEIGHT+WIDTH-1
    logic [RW-1:0]      r_r;     // read row pointer during SEND
    logic [WIDTH-1:0]   r_en;
    logic [WIDTH-1:0]   r_clr;

    // Column w is enabled for HEIGHT cycles starting at t = w.
    function automatic logic [WIDTH-1:0] en_mask(input int t);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int w = 0; w < WIDTH; w++) begin
            m[w] = (t >= w) && (t <= w + HEIGHT - 1);
        end
        return m;
    endfunction

    // Clear lands on the cycle right after a column's last enable, so it can
    // never overlap that column's enable.
    function automatic logic [WIDTH-1:0] clr_mask(input int t);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int w = 0; w < WIDTH; w++) begin
            m[w] = (t == w + HEIGHT);
        end
        return m;
    endfunction

    // en_o/clr_o are registered: each transition loads the masks for the
    // value t will hold in the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_r     <= '0;
            r_en    <= '0;
            r_clr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= DRAIN;
                        r_t     <= '0;
                        r_en    <= en_mask(0);
                        r_clr   <= clr_mask(0);
                    end
                end
                DRAIN: begin
                    if (int'(r_t) == T_LAST) begin
                        r_state <= SEND;
                        r_r     <= '0;
                        r_en    <= '0;
                        r_clr   <= '0;
                    end else begin
                        r_t     <= r_t + 1'b1;
                        r_en    <= en_mask(int'(r_t) + 1);
                        r_clr   <= clr_mask(int'(r_t) + 1);
                    end
                end
                SEND: begin
                    if (bus.out_rdy) begin
                        if (int'(r_r) == HEIGHT - 1) begin
                            r_state <= IDLE;
                            r_r     <= '0;
                        end else begin
                            r_r     <= r_r + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Per-column result buffer. Column gi delivers its k-th result one cycle
    // after its k-th enable, i.e. at t = gi+1+k; that result belongs to row k.
    // The read is gated by SEND so stale buffer contents never leak out.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
        logic [OWIDTH-1:0] r_col [HEIGHT];

        always_ff @(posedge clk) begin
            if (r_state == DRAIN && int'(r_t) >= gi + 1 && int'(r_t) <= gi + HEIGHT) begin
                r_col[RW'(int'(r_t) - gi - 1)] <= bus.ofm[gi];
            end
        end

        assign bus.out_data[gi] = (r_state == SEND) ? r_col[r_r] : '0;
    end

    assign bus.en_o     = r_en;
    assign bus.clr_o    = r_clr;
    assign bus.out_vld  = (r_state == SEND);
    assign bus.out_row  = r_r;
    assign bus.out_last = (r_state == SEND) && (int'(r_r) == HEIGHT - 1);
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_ofm_drain.sv
// tb_ofm_drain -- randomized bench for ofm_drain against a timeline model.
// The array is modelled as a per-column shift-out: after the k-th enable of
// column w it presents vals[k][w]. Expected outputs come from the tile
// timeline (drain time t, then rows in order) rather than the FSM encoding.
module tb_ofm_drain;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int OW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ofm_drain_if #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW)) ifc ();
    ofm_drain #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    ofm_drain_if #(.HEIGHT(1), .WIDTH(1), .OWIDTH(OW)) ifc1 ();
    ofm_drain #(.HEIGHT(1), .WIDTH(1), .OWIDTH(OW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            drain_t = -1;   // -1 when not draining
    bit            sending = 1'b0;
    int            send_r  = 0;
    logic [OW-1:0] vals [H][W];
    int            cnt [W];
    bit            use_pattern = 1'b1;
    int            rows_model = 0;
    int            rows_dut   = 0;

    task automatic new_tile();
        for (int k = 0; k < H; k++)
            for (int w = 0; w < W; w++)
                vals[k][w] = use_pattern ? OW'(100 * w + k) : OW'($urandom);
        for (int w = 0; w < W; w++) cnt[w] = 0;
    endtask

    // One clock cycle: check outputs at negedge, then advance model after posedge.
    task automatic cycle();
        logic [W-1:0]    en_obs;
        logic [W-1:0]    exp_en;
        logic [W-1:0]    exp_clr;
        logic [W*OW-1:0] exp_data;
        @(negedge clk);
        exp_en   = '0;
        exp_clr  = '0;
        exp_data = '0;
        for (int w = 0; w < W; w++) begin
            exp_en[w]  = (drain_t >= w) && (drain_t <= w + H - 1);
            exp_clr[w] = (drain_t >= 0) && (drain_t == w + H);
            if (sending) exp_data[w*OW +: OW] = vals[send_r][w];
        end
        check("en_o", 128'(ifc.en_o), 128'(exp_en));
        check("clr_o", 128'(ifc.clr_o), 128'(exp_clr));
        check("busy", 128'(ifc.busy), 128'((drain_t >= 0) || sending));
        check("out_vld", 128'(ifc.out_vld), 128'(sending));
        check("out_data", 128'(ifc.out_data), 128'(exp_data));
        if (sending) begin
            check("out_row", 128'(ifc.out_row), 128'(send_r));
            check("out_last", 128'(ifc.out_last), 128'(send_r == H - 1));
        end
        if (ifc.out_vld === 1'b1 && ifc.out_rdy === 1'b1) rows_dut++;
        en_obs = ifc.en_o;
        @(posedge clk);
        #1;
        if (drain_t >= 0) begin
            drain_t++;
            if (drain_t == H + W) begin
                drain_t = -1;
                sending = 1'b1;
                send_r  = 0;
            end
        end else if (sending) begin
            if (ifc.out_rdy) begin
                rows_model++;
                send_r++;
                if (send_r == H) sending = 1'b0;
            end
        end else if (ifc.start) begin
            drain_t = 0;
            new_tile();
        end
        for (int w = 0; w < W; w++) begin
            if (en_obs[w] === 1'b1) begin
                if (cnt[w] < H) ifc.ofm[w] = vals[cnt[w]][w];
                cnt[w]++;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        ifc.start     = 1'b0;
        ifc.out_rdy   = 1'b0;
        ifc.ofm       = '0;
        ifc1.start    = 1'b0;
        ifc1.out_rdy  = 1'b0;
        ifc1.ofm      = '0;
        for (int w = 0; w < W; w++) cnt[w] = 0;
        new_tile();
        #12;
        check("rst_en", 128'(ifc.en_o), 128'(0));
        check("rst_clr", 128'(ifc.clr_o), 128'(0));
        check("rst_busy", 128'(ifc.busy), 128'(0));
        check("rst_vld", 128'(ifc.out_vld), 128'(0));
        check("rst_data", 128'(ifc.out_data), 128'(0));
        check("rst_row", 128'(ifc.out_row), 128'(0));
        check("rst_last", 128'(ifc.out_last), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic drain with the 100*w+k pattern, downstream always ready
        use_pattern = 1'b1;
        ifc.out_rdy = 1'b1;
        ifc.start   = 1'b1;
        cycle();
        ifc.start = 1'b0;
        repeat (H + W + H + 2) cycle();

        // Backpressure: 5 cycles of out_rdy=0 once SEND is entered
        use_pattern = 1'b0;
        ifc.out_rdy = 1'b0;
        ifc.start   = 1'b1;
        cycle();
        ifc.start = 1'b0;
        repeat (H + W) cycle();
        repeat (5) cycle();
        ifc.out_rdy = 1'b1;
        repeat (H + 2) cycle();

        // Start while busy: during DRAIN, during SEND, and on the final handshake
        for (int i = 0; i < H + W + H + 3; i++) begin
            ifc.start = (i == 0) || (i == 3) || (i == H + W + 1) || (i == H + W + H);
            cycle();
        end
        ifc.start = 1'b0;
        repeat (3) cycle();

        // Random start/ready traffic
        for (int i = 0; i < 400; i++) begin
            ifc.start   = ($urandom % 6) == 0;
            ifc.out_rdy = ($urandom % 3) != 0;
            cycle();
        end
        ifc.start   = 1'b0;
        ifc.out_rdy = 1'b1;
        repeat (H + W + H + 4) cycle();

        // Asynchronous reset at t=2 of DRAIN, between clock edges
        use_pattern = 1'b1;
        ifc.start   = 1'b1;
        cycle();
        ifc.start = 1'b0;
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_en", 128'(ifc.en_o), 128'(0));
        check("arst_clr", 128'(ifc.clr_o), 128'(0));
        check("arst_busy", 128'(ifc.busy), 128'(0));
        check("arst_vld", 128'(ifc.out_vld), 128'(0));
        drain_t = -1;
        sending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();
        ifc.start = 1'b1;
        cycle();
        ifc.start = 1'b0;
        repeat (H + W + H + 2) cycle();
        check("row_count", 128'(rows_dut), 128'(rows_model));

        // 1x1 instance with an all-ones result
        ifc1.ofm     = '1;
        ifc1.out_rdy = 1'b1;
        ifc1.start   = 1'b1;
        @(posedge clk);
        #1;
        ifc1.start = 1'b0;
        @(negedge clk);
        check("x1_en_t0", 128'(ifc1.en_o), 128'(1));
        check("x1_clr_t0", 128'(ifc1.clr_o), 128'(0));
        check("x1_busy", 128'(ifc1.busy), 128'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("x1_en_t1", 128'(ifc1.en_o), 128'(0));
        check("x1_clr_t1", 128'(ifc1.clr_o), 128'(1));
        check("x1_vld_t1", 128'(ifc1.out_vld), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("x1_vld", 128'(ifc1.out_vld), 128'(1));
        check("x1_data", 128'(ifc1.out_data), 128'(24'hFFFFFF));
        check("x1_row", 128'(ifc1.out_row), 128'(0));
        check("x1_last", 128'(ifc1.out_last), 128'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("x1_idle_vld", 128'(ifc1.out_vld), 128'(0));
        check("x1_idle_busy", 128'(ifc1.busy), 128'(0));
        check("x1_idle_data", 128'(ifc1.out_data), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
